addsub_op_sequencer: RTL and testbench

Upstream issue stage for the team's combinational 4-bit adder-subtractor, which has ports a, b, sub, sum and cout. It accepts add/subtract commands over a valid/ready handshake and queues them in a small FIFO. It drives one command at a time onto the adder-subtractor's operand pins, then registers the returned sum/cout with status flags and presents them downstream over a second valid/ready handshake.

---
 rtl/addsub_op_sequencer.sv | 172 +++++++++++++++++
 tb/tb_addsub_op_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_op_sequencer.sv
// Issue stage for the 4-bit adder-subtractor: command FIFO, operand
// issue, result capture with status flags, and a completed-op counter.
module addsub_op_sequencer #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic [W-1:0] as_a,
  output logic [W-1:0] as_b,
  output logic         as_sub,
  input  logic [W-1:0] as_sum,
  input  logic         as_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_cout,
  output logic         out_zero,
  output logic         out_ovf,
  output logic [7:0]   op_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2
  } state_t;

  cmd_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;

  logic [W-1:0]  as_a_q, as_a_d;
  logic [W-1:0]  as_b_q, as_b_d;
  logic          as_sub_q, as_sub_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_result_q, out_result_d;
  logic          out_cout_q, out_cout_d;
  logic          out_zero_q, out_zero_d;
  logic          out_ovf_q, out_ovf_d;
  logic [7:0]    op_count_q, op_count_d;

  logic          push, pop;
  logic [W-1:0]  b_eff;
  cmd_t          head;

  assign in_ready = (cnt_q < CW'(DEPTH)) & rst_n;
  assign push     = in_valid & in_ready;
  assign head     = mem_q[rd_ptr_q];
  assign b_eff    = as_sub_q ? ~as_b_q : as_b_q;

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    as_a_d       = as_a_q;
    as_b_d       = as_b_q;
    as_sub_d     = as_sub_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_cout_d   = out_cout_q;
    out_zero_d   = out_zero_q;
    out_ovf_d    = out_ovf_q;
    op_count_d   = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        out_result_d = as_sum;
        out_cout_d   = as_cout;
        out_zero_d   = (as_sum == '0);
        out_ovf_d    = (as_a_q[W-1] == b_eff[W-1]) &
                       (as_sum[W-1] != as_a_q[W-1]);
        out_valid_d  = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          if (cnt_q != '0) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      as_a_d   = head.a;
      as_b_d   = head.b;
      as_sub_d = head.sub;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage has no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: in_a, b: in_b, sub: in_sub};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      as_a_q       <= '0;
      as_b_q       <= '0;
      as_sub_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_cout_q   <= 1'b0;
      out_zero_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      as_a_q       <= as_a_d;
      as_b_q       <= as_b_d;
      as_sub_q     <= as_sub_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_cout_q   <= out_cout_d;
      out_zero_q   <= out_zero_d;
      out_ovf_q    <= out_ovf_d;
      op_count_q   <= op_count_d;
    end
  end

  assign as_a       = as_a_q;
  assign as_b       = as_b_q;
  assign as_sub     = as_sub_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_cout   = out_cout_q;
  assign out_zero   = out_zero_q;
  assign out_ovf    = out_ovf_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_addsub_op_sequencer.sv
// Bench for addsub_op_sequencer with an attached adder-subtractor
// and a queue-based reference model of the accepted command stream.
module tb_addsub_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b;
  logic       in_sub;
  logic [3:0] as_a, as_b;
  logic       as_sub;
  logic [3:0] as_sum;
  logic       as_cout;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_cout, out_zero, out_ovf;
  logic [7:0] op_count;

  addsub_op_sequencer #(.W(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .as_a(as_a), .as_b(as_b), .as_sub(as_sub),
    .as_sum(as_sum), .as_cout(as_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout),
    .out_zero(out_zero), .out_ovf(out_ovf),
    .op_count(op_count)
  );

  // The combinational adder-subtractor the sequencer drives.
  always_comb begin
    {as_cout, as_sum} = {1'b0, as_a} +
                        {1'b0, (as_sub ? ~as_b : as_b)} +
                        {4'd0, as_sub};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [6:0]  exp_q[$];
  logic [7:0]  exp_cnt = 8'd0;
  bit          last_acc, last_hs;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_snap;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {result[3:0], cout, zero, ovf} from plain integer arithmetic.
  function automatic logic [6:0] ref_op(int a, int b, bit s);
    int r, sa, sb, sr, res;
    bit cout, ovf;
    r    = s ? a - b : a + b;
    res  = (r + 16) % 16;
    cout = s ? (a >= b) : (r > 15);
    sa   = a > 7 ? a - 16 : a;
    sb   = b > 7 ? b - 16 : b;
    sr   = s ? sa - sb : sa + sb;
    ovf  = (sr > 7) || (sr < -8);
    return {res[3:0], cout, (res == 0), ovf};
  endfunction

  function automatic logic [31:0] snap();
    return {19'd0, out_valid, out_result, out_cout, out_zero,
            out_ovf, as_a, as_b, as_sub};
  endfunction

  task automatic step(input bit v, input logic [3:0] a,
                      input logic [3:0] b, input bit s, input bit rdy);
    logic [6:0] e;
    @(negedge clk);
    cyc++;
    if (prev_hold) chk("hold_stable", snap(), prev_snap);
    chk("op_count", {24'd0, op_count}, {24'd0, exp_cnt});
    if (out_valid && exp_q.size() == 0)
      chk("spurious_valid", {31'd0, out_valid}, 32'd0);
    else if (out_valid && rdy) begin
      e = exp_q[0];
      chk("result", {25'd0, out_result, out_cout, out_zero, out_ovf},
          {25'd0, e});
    end
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_sub    = s;
    out_ready = rdy;
    #1;
    last_acc = in_valid & in_ready;
    last_hs  = out_valid & out_ready;
    if (last_hs && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_cnt++;
    end
    if (last_acc) exp_q.push_back(ref_op(int'(a), int'(b), s));
    prev_hold = out_valid & ~out_ready;
    prev_snap = snap();
    @(posedge clk);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
    end
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outs", {24'd0, out_result, out_cout, out_zero,
                     out_ovf, 1'b0}, 32'd0);
    chk("rst_as", {23'd0, as_a, as_b, as_sub}, 32'd0);
    chk("rst_op_count", {24'd0, op_count}, 32'd0);
    exp_q.delete();
    exp_cnt   = 8'd0;
    prev_hold = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  logic [3:0] ca [5] = '{4'd3, 4'd2, 4'd7, 4'd8, 4'd15};
  logic [3:0] cb [5] = '{4'd3, 4'd3, 4'd1, 4'd1, 4'd1};
  bit         cs [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [6:0] ce [5] = '{7'b0000_110, 7'b1111_000, 7'b1000_001,
                         7'b0111_101, 7'b0000_110};

  initial begin
    int acc_n, hs_n, last_cyc;
    bit f_acc;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_sub = 1'b0; out_ready = 1'b0;

    reset_cycles(2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    #2;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_idle", {31'd0, out_valid}, 32'd0);

    // Single add and latency.
    step(1, 4'd3, 4'd2, 0, 1);
    #2 chk("lat_n0_valid", {31'd0, out_valid}, 32'd0);
    step(0, 0, 0, 0, 1);
    #2 chk("lat_n1_as_a", {28'd0, as_a}, 32'd3);
    chk("lat_n1_valid", {31'd0, out_valid}, 32'd0);
    step(0, 0, 0, 0, 0);
    #2 chk("lat_n2_valid", {31'd0, out_valid}, 32'd1);
    chk("add_fields", {25'd0, out_result, out_cout, out_zero, out_ovf},
        {25'd0, 7'b0101_000});
    step(0, 0, 0, 0, 1);
    #2 chk("add_op_count", {24'd0, op_count}, 32'd1);

    // Arithmetic corners.
    for (int i = 0; i < 5; i++) begin
      step(1, ca[i], cb[i], cs[i], 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      #2 chk($sformatf("corner%0d", i),
             {24'd0, out_valid, out_result, out_cout, out_zero, out_ovf},
             {24'd0, 1'b1, ce[i]});
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
    end

    // Backpressure: six commands against a stalled consumer.
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 4'(i + 1), 4'(12 - i), i[0], 0);
      acc_n += int'(last_acc);
    end
    #2 chk("bp_accepted", acc_n, 5);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step(1, 4'd9, 4'd4, 1, 0);
      acc_n += int'(last_acc);
    end
    chk("bp_held_off", acc_n, 5);
    hs_n = 0; f_acc = 1'b0; last_cyc = 0;
    for (int k = 0; k < 60 && hs_n < 6; k++) begin
      step(!f_acc, 4'd9, 4'd4, 1, 1);
      if (last_acc) f_acc = 1'b1;
      if (last_hs) begin
        if (hs_n > 0 && hs_n < 5) chk("bp_spacing", cyc - last_cyc, 2);
        last_cyc = cyc;
        hs_n++;
      end
    end
    chk("bp_drained", hs_n, 6);
    chk("bp_sixth_acc", {31'd0, f_acc}, 32'd1);

    // Reset with three queued and one result pending.
    for (int i = 0; i < 4; i++) step(1, 4'(i), 4'(i + 5), 0, 0);
    #2 chk("mid_valid", {31'd0, out_valid}, 32'd1);
    reset_cycles(1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    #2 chk("mid_no_stale", {31'd0, out_valid}, 32'd0);

    // Random traffic through 256 transfers, then one more.
    acc_n = 0; hs_n = 0;
    for (int k = 0; k < 6000 && hs_n < 256; k++) begin
      step(acc_n < 256 && ($urandom % 4 != 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom % 2), ($urandom % 3 != 0));
      acc_n += int'(last_acc);
      hs_n  += int'(last_hs);
    end
    chk("wrap_transfers", hs_n, 256);
    #2 chk("wrap_zero", {24'd0, op_count}, 32'd0);
    step(1, 4'd5, 4'd6, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    #2 chk("wrap_one", {24'd0, op_count}, 32'd1);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
